// File: rtl/disp_scan_ctrl.sv
// Binary-to-BCD (sequential double-dabble) plus 4-digit time-multiplexed display scan.
// Optional leading-zero blanking enabled by defining DISP_SCAN_LZB_EN.
module disp_scan_ctrl #(
  parameter int unsigned BIN_W       = 14,
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [BIN_W-1:0] value,
  output logic             busy,
  output logic             ovf,
  output logic [1:0]       en,
  output logic [3:0]       num
);

  localparam int unsigned CntW  = $clog2(REFRESH_DIV);
  localparam int unsigned IterW = 5;

  typedef enum logic [0:0] {StIdle, StConv} state_e;

  state_e             state_q, state_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [15:0]        bcd_q, bcd_d, bcd_adj;
  logic [IterW-1:0]   iter_q, iter_d;
  logic               pend_ovf_q, pend_ovf_d;
  logic [15:0]        digits_q, digits_d;
  logic               ovf_q, ovf_d;
  logic [CntW-1:0]    refresh_cnt_q;
  logic [1:0]         en_q;

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    iter_d     = iter_q;
    pend_ovf_d = pend_ovf_q;
    digits_d   = digits_q;
    ovf_d      = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (load) begin
          bin_d      = value;
          bcd_d      = '0;
          iter_d     = '0;
          pend_ovf_d = (32'(value) > 32'd9999);
          state_d    = StConv;
        end
      end
      StConv: begin
        // Bits shifted out of the top BCD nibble are dropped; ovf covers that case.
        bcd_d  = (bcd_adj << 1) | 16'(bin_q[BIN_W-1]);
        bin_d  = bin_q << 1;
        iter_d = iter_q + 1'b1;
        if (iter_q == IterW'(BIN_W - 1)) begin
          digits_d = bcd_d;
          ovf_d    = pend_ovf_q;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      bin_q      <= '0;
      bcd_q      <= '0;
      iter_q     <= '0;
      pend_ovf_q <= 1'b0;
      digits_q   <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      iter_q     <= iter_d;
      pend_ovf_q <= pend_ovf_d;
      digits_q   <= digits_d;
      ovf_q      <= ovf_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refresh_cnt_q <= '0;
      en_q          <= 2'd0;
    end else if (refresh_cnt_q == CntW'(REFRESH_DIV - 1)) begin
      refresh_cnt_q <= '0;
      en_q          <= en_q + 2'd1;
    end else begin
      refresh_cnt_q <= refresh_cnt_q + 1'b1;
    end
  end

  logic [3:0] digit_sel;
  logic       blank;

  always_comb begin
    digit_sel = 4'd0;
    unique case (en_q)
      2'd0: digit_sel = digits_q[3:0];
      2'd1: digit_sel = digits_q[7:4];
      2'd2: digit_sel = digits_q[11:8];
      2'd3: digit_sel = digits_q[15:12];
      default: digit_sel = 4'd0;
    endcase
  end

`ifdef DISP_SCAN_LZB_EN
  logic [3:1] lz;
  always_comb begin
    lz[3] = (digits_q[15:12] == 4'd0);
    lz[2] = lz[3] && (digits_q[11:8] == 4'd0);
    lz[1] = lz[2] && (digits_q[7:4] == 4'd0);
    blank = 1'b0;
    if (en_q != 2'd0) blank = lz[en_q];
  end
`else
  assign blank = 1'b0;
`endif

  assign num  = (ovf_q || blank) ? 4'hF : digit_sel;
  assign busy = (state_q == StConv);
  assign ovf  = ovf_q;
  assign en   = en_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed self-checking bench for disp_scan_ctrl (BIN_W=14, REFRESH_DIV=4).
module tb_disp_scan_ctrl;

  localparam int unsigned BinW   = 14;
  localparam int unsigned RefDiv = 4;
`ifdef DISP_SCAN_LZB_EN
  localparam logic [3:0] Lz = 4'hF;
`else
  localparam logic [3:0] Lz = 4'h0;
`endif

  logic            clk   = 1'b0;
  logic            rst_n = 1'b0;
  logic            load  = 1'b0;
  logic [BinW-1:0] value = '0;
  logic            busy;
  logic            ovf;
  logic [1:0]      en;
  logic [3:0]      num;

  int checks = 0;
  int errors = 0;
  int n;

  disp_scan_ctrl #(
    .BIN_W      (BinW),
    .REFRESH_DIV(RefDiv)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .load (load),
    .value(value),
    .busy (busy),
    .ovf  (ovf),
    .en   (en),
    .num  (num)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_load(input logic [BinW-1:0] v);
    value = v;
    load  = 1'b1;
    tick();
    load  = 1'b0;
  endtask

  task automatic load_and_wait(input logic [BinW-1:0] v);
    int c;
    start_load(v);
    c = 0;
    while (busy && c < 40) begin
      tick();
      c++;
    end
    chk("busy_len", 16'(c), 16'd14);
  endtask

  task automatic check_digits(input string tag, input logic [3:0] e0, input logic [3:0] e1,
                              input logic [3:0] e2, input logic [3:0] e3);
    logic [3:0] exp_a [4];
    exp_a[0] = e0;
    exp_a[1] = e1;
    exp_a[2] = e2;
    exp_a[3] = e3;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 20 && en != 2'(k); i++) tick();
      chk($sformatf("%s_en%0d", tag, k), 16'(en), 16'(k));
      chk($sformatf("%s_num%0d", tag, k), 16'(num), 16'(exp_a[k]));
    end
  endtask

  task automatic scan_steps(input string tag);
    for (int i = 0; i <= 16; i++) begin
      chk($sformatf("%s_t%0d", tag, i), 16'(en), 16'((i / 4) % 4));
      tick();
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_ovf", 16'(ovf), 16'd0);
    chk("rst_en", 16'(en), 16'd0);
    chk("rst_num", 16'(num), 16'd0);
    rst_n = 1'b1;
    scan_steps("scan0");

    // Normal conversion with busy length check
    start_load(14'd1234);
    chk("busy_rise", 16'(busy), 16'd1);
    n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
    chk("busy_len_1234", 16'(n), 16'd14);
    chk("ovf_1234", 16'(ovf), 16'd0);
    check_digits("d1234", 4'd4, 4'd3, 4'd2, 4'd1);

    load_and_wait(14'd9999);
    chk("ovf_9999", 16'(ovf), 16'd0);
    check_digits("d9999", 4'd9, 4'd9, 4'd9, 4'd9);

    load_and_wait(14'd10000);
    chk("ovf_10000", 16'(ovf), 16'd1);
    check_digits("d10000", 4'hF, 4'hF, 4'hF, 4'hF);

    load_and_wait(14'd0);
    chk("ovf_0", 16'(ovf), 16'd0);
    check_digits("d0", 4'd0, Lz, Lz, Lz);

    // Load pulse during busy must be ignored
    start_load(14'd1234);
    n = 0;
    repeat (4) begin
      tick();
      n++;
    end
    value = 14'd5678;
    load  = 1'b1;
    tick();
    load  = 1'b0;
    n++;
    while (busy && n < 40) begin
      tick();
      n++;
    end
    chk("busy_len_ign", 16'(n), 16'd14);
    check_digits("ign", 4'd4, 4'd3, 4'd2, 4'd1);
    load_and_wait(14'd5678);
    check_digits("d5678", 4'd8, 4'd7, 4'd6, 4'd5);

    // Asynchronous reset in the middle of a conversion
    start_load(14'd4321);
    repeat (6) tick();
    chk("mid_busy", 16'(busy), 16'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 16'(busy), 16'd0);
    chk("arst_ovf", 16'(ovf), 16'd0);
    chk("arst_en", 16'(en), 16'd0);
    chk("arst_num", 16'(num), 16'd0);
    tick();
    rst_n = 1'b1;
    scan_steps("scan1");
    chk("post_rst_busy", 16'(busy), 16'd0);
    check_digits("post_rst", 4'd0, Lz, Lz, Lz);
    load_and_wait(14'd42);
    check_digits("d42", 4'd2, 4'd4, Lz, Lz);

    load_and_wait(14'd7);
    check_digits("d7", 4'd7, Lz, Lz, Lz);
    load_and_wait(14'd1005);
    check_digits("d1005", 4'd5, 4'd0, 4'd0, 4'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
